// File: rtl/dcf_frame_decoder_pkg.sv
// Shared constants, state encoding and frame check for the DCF77 receive path.
package dcf_frame_decoder_pkg;

    // Slicer thresholds on the Goertzel magnitude, with hysteresis between them
    localparam logic [15:0] ThOn  = 16'd900;
    localparam logic [15:0] ThOff = 16'd600;
    localparam int unsigned Debounce = 5;

    // One spare bit so that a run length (count + 1) never wraps
    localparam int unsigned RunW = 13;
    typedef logic [RunW:0] run_len_t;

    localparam run_len_t PulseMin = 14'd125;
    localparam run_len_t BitSplit = 14'd375;
    localparam run_len_t PulseMax = 14'd625;
    localparam run_len_t MarkMin  = 14'd3750;
    localparam run_len_t MarkMax  = 14'd6250;
    localparam logic [RunW-1:0] RunSat = '1;

    localparam int unsigned FrameLen = 59;
    localparam logic [5:0]  FrameBits = 6'd59;
    localparam int unsigned BitStart = 0;
    localparam int unsigned BitS20   = 20;
    localparam int unsigned BitP1    = 28;
    localparam int unsigned BitP2    = 35;
    localparam int unsigned BitP3    = 58;

    typedef enum logic [1:0] {
        StSearch,
        StGap,
        StPulse
    } dcf_state_e;

    function automatic logic frame_ok(input logic [FrameLen-1:0] f);
        frame_ok = !f[BitStart] && f[BitS20]
                   && !(^f[BitP1:BitS20+1])
                   && !(^f[BitP2:BitP1+1])
                   && !(^f[BitP3:BitP2+1]);
    endfunction

endpackage

// File: rtl/dcf_frame_decoder_level_filter.sv
// Hysteresis slicer plus debounce: turns magnitude samples into a clean carrier level
// with single-cycle rise/fall strobes in the cycle of the sample that completes debounce.
module dcf_level_filter
    import dcf_frame_decoder_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        sample_valid_i,
    input  logic [15:0] magnitude_i,
    output logic        level_o,
    output logic        rise_o,
    output logic        fall_o
);

    localparam logic [2:0] DebLast = 3'(Debounce - 1);

    logic       raw_q, raw_d;
    logic       level_q, level_d;
    logic [2:0] deb_q, deb_d;

    always_comb begin
        raw_d   = raw_q;
        level_d = level_q;
        deb_d   = deb_q;
        rise_o  = 1'b0;
        fall_o  = 1'b0;
        if (sample_valid_i) begin
            if (magnitude_i >= ThOn) begin
                raw_d = 1'b1;
            end else if (magnitude_i < ThOff) begin
                raw_d = 1'b0;
            end
            if (raw_d != level_q) begin
                if (deb_q == DebLast) begin
                    level_d = raw_d;
                    deb_d   = '0;
                    rise_o  = raw_d;
                    fall_o  = !raw_d;
                end else begin
                    deb_d = deb_q + 3'd1;
                end
            end else begin
                deb_d = '0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            raw_q   <= 1'b0;
            level_q <= 1'b0;
            deb_q   <= '0;
        end else begin
            raw_q   <= raw_d;
            level_q <= level_d;
            deb_q   <= deb_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/dcf_frame_decoder.sv
// DCF77 frame decoder: measures pulse/gap widths of the filtered carrier level, finds the
// minute marker, collects 59 bits into a shadow register and publishes checked frames.
module dcf_frame_decoder
    import dcf_frame_decoder_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] magnitude,
    output logic        bit_strobe,
    output logic        bit_value,
    output logic [5:0]  bit_count,
    output logic        sync,
    output logic [58:0] time_data,
    output logic        frame_valid,
    output logic        frame_error
);

    logic level, rise, fall;

    dcf_level_filter u_filter (
        .clock_i        (clock),
        .reset_i        (reset),
        .sample_valid_i (sample_valid),
        .magnitude_i    (magnitude),
        .level_o        (level),
        .rise_o         (rise),
        .fall_o         (fall)
    );

    dcf_state_e          state_q, state_d;
    logic [RunW-1:0]     run_cnt_q, run_cnt_d;
    logic [5:0]          bit_count_q, bit_count_d;
    logic                sync_q, sync_d;
    logic [FrameLen-1:0] shadow_q, shadow_d;
    logic [FrameLen-1:0] time_data_q, time_data_d;
    logic                bit_strobe_q, bit_strobe_d;
    logic                bit_value_q, bit_value_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_error_q, frame_error_d;

    run_len_t run_now;   // count after this sample
    run_len_t width;     // length of the run that ends at this edge
    logic     new_bit;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (sample_valid) begin
            if (rise || fall) begin
                run_cnt_d = '0;
            end else if (run_cnt_q != RunSat) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end
    end

    assign run_now = {1'b0, run_cnt_d};
    assign width   = {1'b0, run_cnt_q} + 14'd1;
    assign new_bit = (width >= BitSplit);

    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        sync_d        = sync_q;
        shadow_d      = shadow_q;
        time_data_d   = time_data_q;
        bit_strobe_d  = 1'b0;
        bit_value_d   = bit_value_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        if (sample_valid) begin
            case (state_q)
                StSearch: begin
                    if (!level && run_now == MarkMin) begin
                        sync_d      = 1'b1;
                        bit_count_d = '0;
                        state_d     = StGap;
                    end
                end
                StGap: begin
                    if (rise) begin
                        if (width >= MarkMin) begin
                            // An empty frame (first marker after sync) is not an error
                            if (bit_count_q == FrameBits && frame_ok(shadow_q)) begin
                                time_data_d   = shadow_q;
                                frame_valid_d = 1'b1;
                            end else if (bit_count_q != '0) begin
                                frame_error_d = 1'b1;
                            end
                            bit_count_d = '0;
                        end
                        state_d = StPulse;
                    end else if (run_now == MarkMax) begin
                        frame_error_d = (bit_count_q != '0);
                        sync_d        = 1'b0;
                        bit_count_d   = '0;
                        state_d       = StSearch;
                    end
                end
                StPulse: begin
                    if (fall) begin
                        if (bit_count_q == FrameBits || width < PulseMin || width > PulseMax) begin
                            frame_error_d = 1'b1;
                            sync_d        = 1'b0;
                            bit_count_d   = '0;
                            state_d       = StSearch;
                        end else begin
                            shadow_d[bit_count_q] = new_bit;
                            bit_count_d           = bit_count_q + 6'd1;
                            bit_strobe_d          = 1'b1;
                            bit_value_d           = new_bit;
                            state_d               = StGap;
                        end
                    end else if (run_now > PulseMax) begin
                        frame_error_d = 1'b1;
                        sync_d        = 1'b0;
                        bit_count_d   = '0;
                        state_d       = StSearch;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StSearch;
            run_cnt_q     <= '0;
            bit_count_q   <= '0;
            sync_q        <= 1'b0;
            shadow_q      <= '0;
            time_data_q   <= '0;
            bit_strobe_q  <= 1'b0;
            bit_value_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            bit_count_q   <= bit_count_d;
            sync_q        <= sync_d;
            shadow_q      <= shadow_d;
            time_data_q   <= time_data_d;
            bit_strobe_q  <= bit_strobe_d;
            bit_value_q   <= bit_value_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bit_strobe  = bit_strobe_q;
    assign bit_value   = bit_value_q;
    assign bit_count   = bit_count_q;
    assign sync        = sync_q;
    assign time_data   = time_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;

endmodule
